// File: rtl/aip_conv_host.sv
// aip_conv_host: host-side initiator that runs one AIP convolution job per request.
// Sequence: config write, X/Y sample bursts, start, wait interrupt, clear, Z readback.
module aip_conv_host #(
  parameter logic [4:0]  CODE_MEMX   = 5'd0,
  parameter logic [4:0]  CODE_MEMY   = 5'd2,
  parameter logic [4:0]  CODE_CREG   = 5'd4,
  parameter logic [4:0]  CODE_MEMZ   = 5'd1,
  parameter logic [4:0]  CODE_STATUS = 5'd30,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic        job_start,
  input  logic [6:0]  size_x,
  input  logic [6:0]  size_y,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        aip_en,
  output logic [31:0] aip_data_in,
  input  logic [31:0] aip_data_out,
  output logic [4:0]  aip_conf,
  output logic        aip_write,
  output logic        aip_read,
  output logic        aip_start,
  input  logic        aip_int
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_SEL_X,
    S_WR_X,
    S_SEL_Y,
    S_WR_Y,
    S_GO,
    S_WAIT,
    S_CLR,
    S_SEL_Z,
    S_RD_Z,
    S_FIN
  } state_t;

  state_t        state;
  logic [6:0]    sx_q;
  logic [6:0]    sy_q;
  logic [6:0]    len_q;
  logic [6:0]    beat_cnt;
  logic [6:0]    rd_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          rd_pend;
  logic          wr_q;
  logic [31:0]   wdata_q;

  logic          in_fire;
  logic          out_fire;
  logic          rd_issue;
  logic [7:0]    len_sum;
  logic          size_bad;
  logic          unused_hi;

  // Job length and admission check on the raw request sizes
  assign len_sum  = {1'b0, size_x} + {1'b0, size_y};
  assign size_bad = (size_x == 7'd0) || (size_y == 7'd0) ||
                    (len_sum > 8'(MEM_DEPTH + 1));

  // Handshakes; a sample beat must reach the AIP in the cycle it is accepted
  assign in_fire   = in_ready & in_valid;
  assign out_fire  = out_valid & out_ready;
  assign rd_issue  = (state == S_RD_Z) && !rd_pend && (rd_cnt < len_q) &&
                     (!out_valid || out_ready);
  assign aip_read  = rd_issue;
  assign aip_write = wr_q | in_fire;
  assign aip_data_in = in_ready ? {24'b0, in_data} : wdata_q;

  // Only the low half of the read data carries a Z result
  assign unused_hi = ^aip_data_out[31:16];

  // Job sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state     <= S_IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      rd_cnt    <= '0;
      tmo_cnt   <= '0;
      rd_pend   <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aip_en    <= 1'b0;
      aip_conf  <= '0;
      aip_start <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      aip_start <= 1'b0;
      done      <= 1'b0;
      rd_pend   <= rd_issue;

      // Read data lands one cycle after the strobe; hold it until consumed
      if (rd_pend) begin
        out_data  <= aip_data_out[15:0];
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (job_start) begin
            sx_q  <= size_x;
            sy_q  <= size_y;
            len_q <= 7'(len_sum - 8'd1);
            if (size_bad) begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= S_CFG;
              busy     <= 1'b1;
              aip_en   <= 1'b1;
              err      <= 1'b0;
              aip_conf <= CODE_CREG;
              wr_q     <= 1'b1;
              wdata_q  <= {26'b0, size_y[5:0]};
            end
          end
        end
        S_CFG: begin
          state    <= S_SEL_X;
          aip_conf <= CODE_MEMX;
        end
        S_SEL_X: begin
          state    <= S_WR_X;
          in_ready <= 1'b1;
          beat_cnt <= '0;
        end
        S_WR_X: begin
          if (in_fire) begin
            if (beat_cnt == sx_q - 7'd1) begin
              state    <= S_SEL_Y;
              in_ready <= 1'b0;
              aip_conf <= CODE_MEMY;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 7'd1;
            end
          end
        end
        S_SEL_Y: begin
          state    <= S_WR_Y;
          in_ready <= 1'b1;
          beat_cnt <= '0;
        end
        S_WR_Y: begin
          if (in_fire) begin
            if (beat_cnt == sy_q - 7'd1) begin
              state     <= S_GO;
              in_ready  <= 1'b0;
              aip_start <= 1'b1;
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + 7'd1;
            end
          end
        end
        S_GO: begin
          state   <= S_WAIT;
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (aip_int) begin
            state    <= S_CLR;
            aip_conf <= CODE_STATUS;
            wr_q     <= 1'b1;
            wdata_q  <= 32'h1;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state    <= S_FIN;
            done     <= 1'b1;
            err      <= 1'b1;
            busy     <= 1'b0;
            aip_en   <= 1'b0;
            aip_conf <= '0;
          end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_CLR: begin
          state    <= S_SEL_Z;
          aip_conf <= CODE_MEMZ;
          rd_cnt   <= '0;
          beat_cnt <= '0;
        end
        S_SEL_Z: begin
          state <= S_RD_Z;
        end
        S_RD_Z: begin
          if (rd_issue) begin
            rd_cnt <= rd_cnt + 7'd1;
          end
          if (out_fire) begin
            if (beat_cnt == len_q - 7'd1) begin
              state    <= S_FIN;
              done     <= 1'b1;
              err      <= 1'b0;
              busy     <= 1'b0;
              aip_en   <= 1'b0;
              aip_conf <= '0;
            end else begin
              beat_cnt <= beat_cnt + 7'd1;
            end
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          err    <= 1'b0;
          busy   <= 1'b0;
          aip_en <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aip_conv_host.sv
// tb_aip_conv_host: scoreboard bench with a behavioural AIP convolutor model.
module tb_aip_conv_host;

  localparam int unsigned TIMEOUT = 4096;
  localparam logic [4:0] C_MEMX = 5'd0;
  localparam logic [4:0] C_MEMY = 5'd2;
  localparam logic [4:0] C_CREG = 5'd4;
  localparam logic [4:0] C_MEMZ = 5'd1;
  localparam logic [4:0] C_STAT = 5'd30;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        job_start = 1'b0;
  logic [6:0]  size_x = '0;
  logic [6:0]  size_y = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;
  logic        aip_en;
  logic [31:0] aip_data_in;
  logic [31:0] aip_data_out = '0;
  logic [4:0]  aip_conf;
  logic        aip_write;
  logic        aip_read;
  logic        aip_start;
  logic        aip_int = 1'b0;

  aip_conv_host dut (
    .clk(clk), .rst_a(rst_a), .job_start(job_start), .size_x(size_x), .size_y(size_y),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .aip_en(aip_en),
    .aip_data_in(aip_data_in), .aip_data_out(aip_data_out), .aip_conf(aip_conf),
    .aip_write(aip_write), .aip_read(aip_read), .aip_start(aip_start), .aip_int(aip_int)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic        err_q[$];
  logic [7:0]  x_in[$];
  logic [7:0]  y_in[$];
  logic [15:0] z_in[$];
  int          ready_mode = 0;
  time         done_time;
  time         t_issue;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // AIP model state
  logic [7:0]  memx[64];
  logic [7:0]  memy[64];
  logic [15:0] memz[64];
  int          ptr = 0;
  logic [4:0]  conf_prev = '0;
  logic        strobe_prev = 1'b0;
  logic        rd_pend_m = 1'b0;
  int          nx = 0;
  int          ny = 0;
  logic [31:0] creg_val = '0;
  int          creg_n = 0, start_n = 0, clr_n = 0, rd_n = 0, strobe_n = 0;
  logic [7:0]  x_log[$];
  logic [7:0]  y_log[$];
  bit          int_en = 1'b1;
  int          int_cnt = 0;
  time         start_time;

  initial begin
    for (int i = 0; i < 64; i++) begin
      memx[i] = '0;
      memy[i] = '0;
      memz[i] = '0;
    end
  end

  // AIP model: pointer per conf, memories, conv on start, interrupt, read pipe
  always @(posedge clk) begin
    int p;
    p = (aip_conf != conf_prev) ? 0 : ptr;
    if ((aip_write || aip_read) && strobe_prev)
      chk("conf_stable", 32'(aip_conf), 32'(conf_prev));
    if (aip_read) chk("single_read", 32'(rd_pend_m), 32'd0);
    if (aip_write || aip_read) strobe_n++;
    if (aip_write) begin
      case (aip_conf)
        C_MEMX: begin
          if (p < 64) memx[p] = aip_data_in[7:0];
          x_log.push_back(aip_data_in[7:0]);
          nx = p + 1;
        end
        C_MEMY: begin
          if (p < 64) memy[p] = aip_data_in[7:0];
          y_log.push_back(aip_data_in[7:0]);
          ny = p + 1;
        end
        C_CREG: begin
          creg_val = aip_data_in;
          creg_n++;
        end
        C_STAT: begin
          if (aip_data_in == 32'h1) begin
            clr_n++;
            aip_int <= 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (aip_read) begin
      aip_data_out <= (aip_conf == C_MEMZ && p < 64) ? {16'h0, memz[p]} : 32'h0;
      rd_n++;
    end
    if (aip_write || aip_read) p++;
    ptr = p;
    conf_prev = aip_conf;
    strobe_prev = aip_write | aip_read;
    rd_pend_m = aip_read;
    if (aip_start) begin
      start_n++;
      start_time = $time;
      for (int k = 0; k < 64; k++) memz[k] = '0;
      for (int i = 0; i < nx && i < 64; i++)
        for (int j = 0; j < ny && j < 64; j++)
          if (i + j < 64) memz[i+j] = memz[i+j] + 16'(memx[i]) * 16'(memy[j]);
      int_cnt = int_en ? 6 : 0;
    end else if (int_cnt > 0) begin
      int_cnt--;
      if (int_cnt == 0) aip_int <= 1'b1;
    end
  end

  // Consumer backpressure
  int rc = 0;
  always @(posedge clk) begin
    #1;
    rc++;
    out_ready = (ready_mode == 0) ? 1'b1 : ((rc % 3) == 0);
  end

  // Monitor: Z stream, hold stability, done/err
  logic        hold_v = 1'b0;
  logic [15:0] hold_d = '0;
  always @(negedge clk) begin
    if (out_valid && hold_v) chk("out_hold", 32'(out_data), 32'(hold_d));
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("z_extra", $sformatf("unexpected result %0h", out_data));
      else chk("z_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (done) begin
      if (err_q.size() == 0) fail("done_extra", "unexpected done pulse");
      else chk("err_flag", 32'(err), 32'(err_q.pop_front()));
    end
  end

  task automatic start_job(input int sx, input int sy);
    job_start = 1'b1;
    size_x = 7'(sx);
    size_y = 7'(sy);
    t_issue = $time;
    @(posedge clk); #1;
    job_start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] v, input int gap);
    bit acc;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = v;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!ok) fail("in_accept", $sformatf("sample %0h never accepted", v));
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; done_time = $time; break; end
    end
    if (!seen) fail("done_wait", $sformatf("no done within %0d cycles", budget));
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int sx, input int sy, input bit gaps, input bit exp_err,
                         input bit feed_data);
    x_log.delete(); y_log.delete();
    creg_n = 0; start_n = 0; clr_n = 0; rd_n = 0; strobe_n = 0;
    foreach (z_in[i]) exp_q.push_back(z_in[i]);
    err_q.push_back(exp_err);
    start_job(sx, sy);
    if (feed_data) begin
      foreach (x_in[i]) feed(x_in[i], gaps ? (i % 3) : 0);
      foreach (y_in[i]) feed(y_in[i], gaps ? ((i + 1) % 3) : 0);
    end
    wait_done(TIMEOUT + 3000);
  endtask

  task automatic check_job(input logic [31:0] creg_exp, input int len);
    chk("creg_beats", 32'(creg_n), 32'd1);
    chk("creg_data", creg_val, creg_exp);
    chk("x_beats", 32'(x_log.size()), 32'(x_in.size()));
    foreach (x_in[i]) if (i < x_log.size()) chk("x_data", 32'(x_log[i]), 32'(x_in[i]));
    chk("y_beats", 32'(y_log.size()), 32'(y_in.size()));
    foreach (y_in[i]) if (i < y_log.size()) chk("y_data", 32'(y_log[i]), 32'(y_in[i]));
    chk("start_pulses", 32'(start_n), 32'd1);
    chk("int_clears", 32'(clr_n), 32'd1);
    chk("z_reads", 32'(rd_n), 32'(len));
    chk("z_left", 32'(exp_q.size()), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic load_basic();
    x_in = '{8'd1, 8'd2, 8'd3, 8'd4};
    y_in = '{8'd1, 8'd1, 8'd1};
    z_in = '{16'd1, 16'd3, 16'd6, 16'd9, 16'd7, 16'd4};
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", {busy, done, err, aip_en}, 32'd0);
    chk("rst_aip_bus", {aip_conf, aip_write, aip_read, aip_start}, 32'd0);
    chk("rst_aip_data", aip_data_in, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(posedge clk); #1;

    // basic job
    load_basic();
    run_job(4, 3, 1'b0, 1'b0, 1'b1);
    check_job(32'h3, 6);

    // backpressure and input gaps
    ready_mode = 1;
    run_job(4, 3, 1'b1, 1'b0, 1'b1);
    check_job(32'h3, 6);
    ready_mode = 0;

    // oversize job rejected
    x_in.delete(); y_in.delete(); z_in.delete();
    run_job(40, 30, 1'b0, 1'b1, 1'b0);
    chk("reject_strobes", 32'(strobe_n), 32'd0);
    chk("reject_latency", 32'(done_time - t_issue <= 25), 32'd1);

    // interrupt never arrives
    int_en = 1'b0;
    x_in = '{8'd1, 8'd2};
    y_in = '{8'd3, 8'd4};
    z_in.delete();
    run_job(2, 2, 1'b0, 1'b1, 1'b1);
    chk("tmo_cycles", 32'(done_time - start_time), 32'(TIMEOUT * 10 + 5));
    chk("tmo_reads", 32'(rd_n), 32'd0);
    chk("tmo_clears", 32'(clr_n), 32'd0);
    int_en = 1'b1;

    // size_x=1, size_y=64
    x_in = '{8'd2};
    y_in.delete(); z_in.delete();
    for (int k = 0; k < 64; k++) begin
      y_in.push_back(8'(k + 1));
      z_in.push_back(16'(2 * (k + 1)));
    end
    run_job(1, 64, 1'b0, 1'b0, 1'b1);
    check_job(32'h0, 64);

    // size_x=64, size_y=1 under backpressure
    ready_mode = 1;
    x_in.delete(); z_in.delete();
    y_in = '{8'd3};
    for (int k = 0; k < 64; k++) begin
      x_in.push_back(8'(k));
      z_in.push_back(16'(3 * k));
    end
    run_job(64, 1, 1'b0, 1'b0, 1'b1);
    check_job(32'h1, 64);
    ready_mode = 0;

    // reset during second Y beat
    start_job(3, 3);
    feed(8'd5, 0); feed(8'd6, 0); feed(8'd7, 0);
    feed(8'd1, 0);
    in_valid = 1'b1;
    in_data = 8'd2;
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_mid_pre_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_strobes", {aip_write, aip_read, aip_start}, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;

    // job after reset
    load_basic();
    run_job(4, 3, 1'b0, 1'b0, 1'b1);
    check_job(32'h3, 6);
    chk("err_left", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aip_conv_host.md
Name: aip_conv_host

Overview:
- Host-side initiator for the AIP register/memory protocol that fronts the convolution IP core. It drives that protocol on the core's behalf.
- Runs one complete convolution job per request:
  - writes the configuration register;
  - streams X and Y samples into the core's input memories;
  - pulses start and waits for the done interrupt;
  - clears the interrupt;
  - reads back size_x+size_y-1 Z results onto a valid/ready output stream.
- Sits between the local datapath (or a bus bridge) and the AIP-wrapped convolutor.

Parameters:
- CODE_MEMX, 5'd0, conf_dbus code selecting input memory X.
- CODE_MEMY, 5'd2, conf_dbus code selecting input memory Y.
- CODE_CREG, 5'd4, conf_dbus code selecting the configuration register.
- CODE_MEMZ, 5'd1, conf_dbus code selecting output memory Z.
- CODE_STATUS, 5'd30, conf_dbus code selecting status/interrupt register.
- MEM_DEPTH, 64, entries per AIP memory; bounds size_x, size_y and Z length.
- TIMEOUT, 4096, max cycles waited for aip_int after start.

Ports:
- clk, input, 1, clock.
- rst_a, input, 1, synchronous active-high reset.
- job_start, input, 1, one-cycle job request; honoured only in IDLE.
- size_x, input, 7, X sample count, 1..MEM_DEPTH; latched on job_start.
- size_y, input, 7, Y sample count, 1..MEM_DEPTH; latched on job_start.
- in_valid, input, 1, X/Y sample valid.
- in_data, input, 8, sample; all X first, then all Y.
- in_ready, output, 1, sample accepted when in_valid&in_ready.
- out_valid, output, 1, Z result valid.
- out_data, output, 16, Z result (data_out[15:0]).
- out_ready, input, 1, consumer ready.
- busy, output, 1, job in progress.
- done, output, 1, one-cycle pulse at job end.
- err, output, 1, valid with done: job rejected or timed out.
- aip_en, output, 1, AIP enable; high while busy.
- aip_data_in, output, 32, write data to AIP.
- aip_data_out, input, 32, read data from AIP.
- aip_conf, output, 5, conf_dbus target select.
- aip_write, output, 1, write strobe, one beat per cycle.
- aip_read, output, 1, read strobe.
- aip_start, output, 1, core start pulse.
- aip_int, input, 1, interrupt request from AIP.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Protocol rules:
  - aip_conf is held stable for a whole burst and changes only in a cycle with no strobe.
  - The AIP pointer resets to 0 on a conf change; each aip_write/aip_read beat auto-increments it.
  - Read data is valid on aip_data_out exactly 1 cycle after aip_read.
- States:
  - IDLE: on job_start, latch sizes, busy=1. If size_x==0, size_y==0, or size_x+size_y-1 > MEM_DEPTH, go to FIN with err=1. Otherwise go to CFG.
  - CFG: aip_conf=CODE_CREG; one write beat with aip_data_in={26'b0,size_y[5:0]}; go to SEL_X.
  - SEL_X: aip_conf=CODE_MEMX with no strobe for 1 cycle; go to WR_X.
  - WR_X: in_ready=1. Each accepted sample produces aip_write=1 in the same cycle with aip_data_in={24'b0,in_data}. After size_x beats, go to SEL_Y.
  - SEL_Y / WR_Y: identical to SEL_X / WR_X, using CODE_MEMY and size_y beats; then go to GO.
  - GO: aip_start=1 for exactly 1 cycle; clear timeout counter; go to WAIT.
  - WAIT: on aip_int, go to CLR. If the counter reaches TIMEOUT with no interrupt, go to FIN with err=1.
  - CLR: aip_conf=CODE_STATUS; one write beat with data 32'h1 (interrupt clear); go to SEL_Z.
  - SEL_Z: aip_conf=CODE_MEMZ, 1 idle cycle; go to RD_Z.
  - RD_Z: at most one read outstanding. aip_read is issued only when no read is pending and out_valid==0, or when out_valid&out_ready occurs this cycle. The cycle after a read, out_data<=aip_data_out[15:0] and out_valid<=1. out_valid holds until out_ready. After size_x+size_y-1 results are handed off, go to FIN.
  - FIN: done=1 (err as set) for 1 cycle; busy=0; aip_en=0; return to IDLE.
- Timing:
  - in_ready is low in every state except WR_X/WR_Y.
  - job_start is ignored while busy.
  - in_valid gaps stall the burst; there is no timeout on input.
- Counters:
  - beat/result counter is 7 bits and never wraps (max 64).
  - timeout counter saturates at TIMEOUT.
- aip_int asserted outside WAIT is ignored.
- Reset mid-job: rst_a returns to IDLE next edge, all strobes deassert, and any partial output word is discarded.

Test Plan:
- size_x=4, size_y=3, X=1,2,3,4, Y=1,1,1; model returns conv → config beat data 32'h3; 4 X beats; 3 Y beats; one aip_start; after aip_int, 32'h1 to CODE_STATUS; 6 reads; out stream 1,3,6,9,7,4; done=1, err=0.
- Same job with out_ready toggling 1-of-3 cycles and in_valid gaps → identical beats/results, never >1 read outstanding, out_data stable while out_valid&!out_ready.
- size_x=40, size_y=30 (len 69>64) → no AIP strobes, done=1, err=1 within 2 cycles.
- Model never raises aip_int → done=1, err=1 exactly TIMEOUT cycles after WAIT entry; no Z reads.
- Boundary size_x=1, size_y=64 → 64 results read; size_x=64, size_y=1 → 64 results, counters correct.
- rst_a asserted during WR_Y beat 2 → next cycle all aip_* strobes 0, busy=0, in_ready=0; new job afterwards completes correctly.
